// File: rtl/gpio_irq_ctrl.sv
// GPIO pad driver, input synchronizer/edge detector and interrupt pending latch.
// Optional input debounce filter is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl #(
   parameter int N_GPIO    = 8,
   parameter int DB_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_GPIO-1:0]     gpio_in,
   output logic [N_GPIO-1:0]     gpio_out,
   output logic [N_GPIO-1:0]     gpio_oe,
   input  logic [N_GPIO-1:0]     Reg_GPIO_en,
   input  logic [N_GPIO-1:0]     Reg_GPIO_out,
   input  logic [N_GPIO-1:0]     Reg_GPIO_int,
   input  logic [2*N_GPIO-1:0]   irq_mode,
   input  logic [N_GPIO-1:0]     irq_clr,
   output logic [N_GPIO-1:0]     gpio_rd,
   output logic [N_GPIO-1:0]     irq_pend,
   output logic                  maip
);

   logic [N_GPIO-1:0] r_out;
   logic [N_GPIO-1:0] r_oe;
   logic [N_GPIO-1:0] r_s1;
   logic [N_GPIO-1:0] r_s2;
   logic [N_GPIO-1:0] r_prev;
   logic [N_GPIO-1:0] r_pend;
   logic [1:0]        r_arm;
   logic [N_GPIO-1:0] w_rd;
   logic [N_GPIO-1:0] w_det_en;
   logic [N_GPIO-1:0] w_set;
   logic              w_armed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out  <= '0;
         r_oe   <= '0;
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
         r_pend <= '0;
         r_arm  <= '0;
      end else begin
         r_out  <= Reg_GPIO_out;
         r_oe   <= Reg_GPIO_en;
         r_s1   <= gpio_in;
         r_s2   <= r_s1;
         r_prev <= w_rd;
         r_pend <= w_set | (r_pend & ~irq_clr);
         if (r_arm != 2'd3) begin
            r_arm <= r_arm + 2'd1;
         end
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

   logic [7:0]        r_db_cnt [N_GPIO];
   logic [N_GPIO-1:0] r_filt;

   // A pin's filtered value follows s2 only after it has differed for DB_CYCLES cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_filt <= '0;
         for (int i = 0; i < N_GPIO; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_GPIO; i++) begin
            if (r_s2[i] != r_filt[i]) begin
               if (r_db_cnt[i] == DB_LAST) begin
                  r_filt[i]   <= r_s2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_rd = r_filt;
`else
   assign w_rd = r_s2;
`endif

   // Holding off detection until the arm counter saturates hides pins already high at reset release.
   assign w_armed  = (r_arm == 2'd3);
   assign w_det_en = {N_GPIO{w_armed}} & ~Reg_GPIO_en & Reg_GPIO_int;

   always_comb begin
      w_set = '0;
      for (int i = 0; i < N_GPIO; i++) begin
         if (w_det_en[i]) begin
            case (irq_mode[2*i +: 2])
               2'b00:   w_set[i] = w_rd[i] & ~r_prev[i];
               2'b01:   w_set[i] = ~w_rd[i] & r_prev[i];
               2'b10:   w_set[i] = w_rd[i] ^ r_prev[i];
               default: w_set[i] = w_rd[i];
            endcase
         end
      end
   end

   assign gpio_out = r_out;
   assign gpio_oe  = r_oe;
   assign gpio_rd  = w_rd;
   assign irq_pend = r_pend;
   assign maip     = |(r_pend & Reg_GPIO_int);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed steps plus randomized traffic against a delay-line reference model.
module tb_gpio_irq_ctrl;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   gpio_in;
   logic [N-1:0]   gpio_out;
   logic [N-1:0]   gpio_oe;
   logic [N-1:0]   Reg_GPIO_en;
   logic [N-1:0]   Reg_GPIO_out;
   logic [N-1:0]   Reg_GPIO_int;
   logic [2*N-1:0] irq_mode;
   logic [N-1:0]   irq_clr;
   logic [N-1:0]   gpio_rd;
   logic [N-1:0]   irq_pend;
   logic           maip;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gpio_irq_ctrl #(.N_GPIO(N), .DB_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .gpio_oe      (gpio_oe),
      .Reg_GPIO_en  (Reg_GPIO_en),
      .Reg_GPIO_out (Reg_GPIO_out),
      .Reg_GPIO_int (Reg_GPIO_int),
      .irq_mode     (irq_mode),
      .irq_clr      (irq_clr),
      .gpio_rd      (gpio_rd),
      .irq_pend     (irq_pend),
      .maip         (maip)
   );

   // Reference model: pin samples taken at each clock edge are kept in a short history;
   // the value seen by detection at edge k is the sample from edge k-2, its predecessor from k-3.
   logic [N-1:0] hist [$];
   logic [N-1:0] m_pend, m_out, m_oe, m_rd;
   int           m_edges;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist.delete();
         repeat (3) hist.push_back('0);
         m_pend  = '0;
         m_out   = '0;
         m_oe    = '0;
         m_rd    = '0;
         m_edges = 0;
      end else begin
         logic [N-1:0] cur, prv, set;
         m_edges++;
         cur = hist[hist.size()-2];
         prv = hist[hist.size()-3];
         set = '0;
         if (m_edges >= 4) begin
            for (int i = 0; i < N; i++) begin
               if (!Reg_GPIO_en[i] && Reg_GPIO_int[i]) begin
                  case (irq_mode[2*i +: 2])
                     2'd0:    set[i] = cur[i] && !prv[i];
                     2'd1:    set[i] = !cur[i] && prv[i];
                     2'd2:    set[i] = cur[i] != prv[i];
                     default: set[i] = cur[i];
                  endcase
               end
            end
         end
         m_pend = set | (m_pend & ~irq_clr);
         hist.push_back(gpio_in);
         if (hist.size() > 3) void'(hist.pop_front());
         m_rd  = hist[hist.size()-2];
         m_out = Reg_GPIO_out;
         m_oe  = Reg_GPIO_en;
      end
   end

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_out"},  gpio_out, m_out);
      chk({tag, "_oe"},   gpio_oe,  m_oe);
      chk({tag, "_rd"},   gpio_rd,  m_rd);
      chk({tag, "_pend"}, irq_pend, m_pend);
      chk({tag, "_maip"}, 8'(maip), 8'(|(m_pend & Reg_GPIO_int)));
   endtask

   // One clock edge passes, then outputs are compared at the following falling edge.
   task automatic cyc(input string tag);
      @(negedge clk);
`ifndef GPIO_DEBOUNCE_EN
      check_model(tag);
`endif
   endtask

   initial begin
      reset        = 1'b0;
      gpio_in      = 8'hFF;
      Reg_GPIO_en  = '0;
      Reg_GPIO_out = '0;
      Reg_GPIO_int = 8'hFF;
      irq_mode     = '0;
      irq_clr      = '0;
      repeat (3) @(negedge clk);
      chk("rst_pend", irq_pend, 8'h00);
      chk("rst_out",  gpio_out, 8'h00);
      chk("rst_oe",   gpio_oe,  8'h00);
      chk("rst_rd",   gpio_rd,  8'h00);
      chk("rst_maip", 8'(maip), 8'h0);
      reset = 1'b1;

`ifndef GPIO_DEBOUNCE_EN
      // Pins high at release must not raise a rising-edge interrupt.
      for (int i = 0; i < 10; i++) begin
         cyc("arm");
         chk("arm_pend", irq_pend, 8'h00);
         chk("arm_maip", 8'(maip), 8'h0);
      end

      // Pad outputs and the input read path.
      Reg_GPIO_int = '0;
      Reg_GPIO_en  = 8'h0F;
      Reg_GPIO_out = 8'hA5;
      cyc("drv");
      chk("drv_oe",  gpio_oe,  8'h0F);
      chk("drv_out", gpio_out, 8'hA5);
      gpio_in = 8'h5F;
      cyc("rd1");
      chk("rd_lat1", gpio_rd, 8'hFF);
      cyc("rd2");
      chk("rd_lat2", gpio_rd, 8'h5F);

      // Pin 5 rising edge, then write-1-to-clear.
      Reg_GPIO_en  = '0;
      Reg_GPIO_int = 8'h20;
      gpio_in      = '0;
      repeat (4) cyc("p5_settle");
      irq_clr = '1;
      cyc("p5_clr0");
      irq_clr = '0;
      gpio_in = 8'h20;
      cyc("p5_e0");
      cyc("p5_e1");
      chk("p5_e1_pend", irq_pend, 8'h00);
      cyc("p5_e2");
      chk("p5_e2_pend", irq_pend, 8'h20);
      chk("p5_e2_maip", 8'(maip), 8'h1);
      irq_clr = 8'h20;
      cyc("p5_clr");
      irq_clr = '0;
      chk("p5_clr_pend", irq_pend, 8'h00);
      chk("p5_clr_maip", 8'(maip), 8'h0);

      // Pin 2 level mode: clear is ineffective while the pin stays high.
      gpio_in      = 8'h24;
      irq_mode     = 16'h0030;
      Reg_GPIO_int = 8'h04;
      repeat (3) cyc("lvl_hi");
      chk("lvl_set", irq_pend & 8'h04, 8'h04);
      irq_clr = 8'h04;
      cyc("lvl_clr_hi");
      irq_clr = '0;
      chk("lvl_clr_hi", irq_pend & 8'h04, 8'h04);
      gpio_in = 8'h20;
      repeat (3) cyc("lvl_lo");
      irq_clr = 8'h04;
      cyc("lvl_clr_lo");
      irq_clr = '0;
      chk("lvl_clr_lo", irq_pend & 8'h04, 8'h00);

      // Pin 0 masking, then same-cycle set and clear on pin 1.
      irq_mode     = '0;
      Reg_GPIO_int = 8'h01;
      gpio_in      = 8'h21;
      repeat (3) cyc("p0_set");
      chk("p0_pend", irq_pend & 8'h01, 8'h01);
      chk("p0_maip", 8'(maip), 8'h1);
      Reg_GPIO_int = 8'h00;
      cyc("p0_mask");
      chk("p0_mask_maip", 8'(maip), 8'h0);
      chk("p0_mask_pend", irq_pend & 8'h01, 8'h01);
      Reg_GPIO_int = 8'h03;
      #1;
      chk("p0_unmask_maip", 8'(maip), 8'h1);
      gpio_in = 8'h23;
      cyc("p1_e0");
      cyc("p1_e1");
      irq_clr = 8'h02;
      cyc("p1_e2");
      irq_clr = '0;
      chk("p1_set_wins", irq_pend & 8'h02, 8'h02);

      // Randomized traffic with a reset asserted partway through.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            reset = 1'b0;
            cyc("rnd_rst");
            chk("rnd_rst_pend", irq_pend, 8'h00);
            chk("rnd_rst_maip", 8'(maip), 8'h0);
            reset = 1'b1;
         end
         if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) gpio_in = 8'($urandom);
         if ($urandom_range(0, 15) == 0) irq_mode = 16'($urandom);
         if ($urandom_range(0, 15) == 0) Reg_GPIO_en = 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) Reg_GPIO_int = 8'($urandom);
         if ($urandom_range(0, 7) == 0) Reg_GPIO_out = 8'($urandom);
         irq_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         cyc("rnd");
      end
`else
      // Debounce: a 3-cycle glitch is discarded, a 6-cycle pulse passes.
      Reg_GPIO_int = 8'h08;
      gpio_in      = '0;
      repeat (20) cyc("db_settle");
      irq_clr = '1;
      cyc("db_clr");
      irq_clr = '0;
      chk("db_clr_pend", irq_pend, 8'h00);
      gpio_in = 8'h08;
      repeat (3) cyc("db_glitch");
      gpio_in = '0;
      repeat (10) cyc("db_glitch_wait");
      chk("db_glitch_rd",   gpio_rd & 8'h08, 8'h00);
      chk("db_glitch_pend", irq_pend, 8'h00);
      gpio_in = 8'h08;
      repeat (6) cyc("db_pulse");
      repeat (4) cyc("db_pulse_wait");
      chk("db_pulse_rd",   gpio_rd & 8'h08, 8'h08);
      chk("db_pulse_pend", irq_pend & 8'h08, 8'h08);
      chk("db_pulse_maip", 8'(maip), 8'h1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- RTL-side GPIO and interrupt controller that drives and samples the 8-bit `gpio` bus of the SIWA wrapper interface.
- Applies the `Reg_GPIO_en`, `Reg_GPIO_out` and `Reg_GPIO_int` register values to the pads.
- Synchronizes and edge-detects input pins, latches per-pin pending interrupts and raises `maip` toward the core.
- Counterpart to the testbench agents that stimulate `gpio` and check `maip` and `Reg_GPIO_*`.

Parameters:
- N_GPIO, 8, number of GPIO pins.
- DB_CYCLES, 4, debounce stable-cycle count; used only with GPIO_DEBOUNCE_EN; legal range 2..255.

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- gpio_in  input  N_GPIO  raw pad input values, asynchronous to clk.
- gpio_out  output  N_GPIO  pad output values.
- gpio_oe  output  N_GPIO  pad output enable; 1 = drive.
- Reg_GPIO_en  input  N_GPIO  direction register; 1 = output, 0 = input.
- Reg_GPIO_out  input  N_GPIO  output data register.
- Reg_GPIO_int  input  N_GPIO  per-pin interrupt enable.
- irq_mode  input  2*N_GPIO  per-pin mode; bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 high level.
- irq_clr  input  N_GPIO  write-1-to-clear pulse for pending bits.
- gpio_rd  output  N_GPIO  synchronized (and filtered, if enabled) pin values.
- irq_pend  output  N_GPIO  pending interrupt bits.
- maip  output  1  machine interrupt request = OR over i of (irq_pend[i] & Reg_GPIO_int[i]).

Behaviour:
- Reset (reset=0, async): gpio_out, gpio_oe, gpio_rd, irq_pend, the synchronizer flops, prev flops and the arm counter all go to 0. maip is therefore 0.
- Outputs:
  - gpio_oe <= Reg_GPIO_en and gpio_out <= Reg_GPIO_out, both registered (1-cycle latency).
  - gpio_out is driven regardless of oe.
- Input path:
  - 2-flop synchronizer s1 <= gpio_in, s2 <= s1.
  - gpio_rd = s2 (or the filtered value, see Optional Feature).
  - prev <= gpio_rd every cycle.
- Arm counter:
  - 2-bit counter increments from 0 after reset release and saturates at 3.
  - Detection is disabled until the count reaches 3, so a pin that is high at reset release does not produce a false rising edge.
- Detect for pin i is active when: armed, Reg_GPIO_en[i]=0 and Reg_GPIO_int[i]=1.
  - rising: gpio_rd & ~prev.
  - falling: ~gpio_rd & prev.
  - both: gpio_rd ^ prev.
  - level: gpio_rd.
- Pending update:
  - irq_pend[i] <= set[i] | (irq_pend[i] & ~irq_clr[i]).
  - Set wins over a same-cycle clear.
  - In level mode a clear is ineffective while the pin stays high.
- Latency (debounce off):
  - Pin change stable before rising edge E0 → s1 at E0, s2/gpio_rd at E1, irq_pend set at E2.
  - maip is combinational from irq_pend, so it is high after E2.
- Masking:
  - Clearing Reg_GPIO_int[i] masks maip immediately but keeps irq_pend[i].
  - Setting Reg_GPIO_int[i] again re-asserts maip if irq_pend[i] is still 1.
- Direction:
  - Switching a pin to output blocks new sets on that pin; existing pending bits are kept.
  - prev keeps tracking, so returning the pin to input does not create a stale edge.
- Mode change mid-operation: takes effect on the next detect cycle; no retroactive events.
- Reset asserted mid-operation clears pending bits and re-runs the arm sequence.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Each pin has an 8-bit counter and a filtered flop.
  - If s2[i] != filt[i], the counter increments; otherwise it resets to 0.
  - When the counter reaches DB_CYCLES-1 while s2 still differs, filt[i] <= s2[i] and the counter clears.
  - Glitches shorter than DB_CYCLES cycles are discarded.
  - gpio_rd = filt, adding DB_CYCLES cycles of latency; filt resets to 0.
- Not defined: no counters; gpio_rd = s2.

Test Plan:
- Reset release with gpio_in=8'hFF, Reg_GPIO_int=8'hFF, all rising mode → irq_pend stays 8'h00 and maip=0 for 10 cycles.
- Reg_GPIO_en=8'h0F, Reg_GPIO_out=8'hA5 → after 1 cycle gpio_oe=8'h0F and gpio_out=8'hA5; gpio_in[7:4] toggles → gpio_rd tracks them 2 cycles later.
- Pin 5 input, rising mode, int enabled, 0→1 stable before E0 → irq_pend=8'h20 and maip=1 at E2; irq_clr=8'h20 for 1 cycle → irq_pend=0 and maip=0 on the next cycle.
- Pin 2 in level mode held high, irq_clr[2] pulsed → irq_pend[2] remains 1; pin driven low, then clear → irq_pend[2]=0.
- Pin 0 pending, Reg_GPIO_int[0]→0 → maip=0 and irq_pend[0]=1; re-enable → maip=1. Same-cycle edge and clear on pin 1 → irq_pend[1]=1.
- GPIO_DEBOUNCE_EN, DB_CYCLES=4: a 3-cycle high glitch on pin 3 → no pend; a 6-cycle high on pin 3 → gpio_rd[3]=1 and irq_pend[3]=1.
